noc_input_unit: RTL and testbench
=================================

Name: noc_input_unit

Overview:
- Per-input-port front end of the router, directly upstream of the crossbar (cb).
- Buffers incoming flits in a small FIFO and computes an XY route from the head flit.
- Presents a request and output-port index to the crossbar, holding it for the whole packet, and streams flits out while granted.
- Returns one credit upstream per flit it forwards.

Parameters:
- DEPTH, 4, FIFO depth in flits (power of two, ≥2).
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  upstream flit valid.
- flit_i  in  flit_t  upstream flit.
- credit_o  out  1  one-cycle pulse per flit popped from the FIFO.
- req_o  out  1  crossbar request, held from head to tail.
- port_o  out  PORT_W  requested output port index (PORT_W = $clog2(PORT_N)).
- grt_i  in  1  crossbar grant for this input.
- valid_o  out  1  flit_o valid toward the crossbar.
- flit_o  out  flit_t  FIFO head flit.
- err_o  out  1  sticky protocol/overflow error.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, req_o=0, port_o=0, valid_o=0, credit_o=0, err_o=0. flit_o is don't-care, driven 0.
- FIFO write:
  - valid_i writes flit_i at the clock edge; the flit is visible at the head the next cycle.
  - Write while full with no pop in the same cycle: flit dropped, err_o set.
  - Write while full with a simultaneous pop: accepted, count unchanged.
- State machine, 2 states, IDLE and ACTIVE:
  - IDLE with a non-empty FIFO and a head flit of type HEAD or SINGLE: register the XY route into port_o, go to ACTIVE next cycle.
  - IDLE with a head flit of type BODY or TAIL: pop and discard it, pulse credit_o, set err_o, stay in IDLE.
  - ACTIVE: req_o=1 and valid_o=!empty. A flit is popped when grt_i && !empty; credit_o pulses that same cycle.
  - ACTIVE: popping a TAIL or SINGLE flit returns to IDLE next cycle, so req_o=0 in the following cycle.
  - req_o stays asserted while the FIFO is empty mid-packet; the crossbar connection is held.
- Latency: flit written at t, head decoded at t+1, req_o/valid_o high at t+2, earliest pop at t+2.
- Streaming throughput is one flit per cycle while grt_i is high.
- XY routing, with dx/dy taken from the head flit:
  - dx>MY_X → EAST
  - dx<MY_X → WEST
  - otherwise dy>MY_Y → NORTH
  - otherwise dy<MY_Y → SOUTH
  - otherwise LOCAL
  - Unsigned compares.
- grt_i while in IDLE: ignored.
- err_o: cleared only by reset.
- Credits: upstream starts with DEPTH credits; the total number of credit_o pulses equals the number of flits popped.

Decomposition:
- noc_pkg holds:
  - PORT_N, PORT_W
  - port enum: LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4
  - flit type enum (2 bits): HEAD, BODY, TAIL, SINGLE
  - X_W=2, Y_W=2, DATA_W=32
  - flit_t = {type, dst_x, dst_y, payload}
  - route function xy_route(dst_x, dst_y, my_x, my_y)
- One sub-module, noc_fifo (parameterised synchronous FIFO with push/pop/full/empty/count), instantiated once.
- The FSM and routing live in noc_input_unit.

Test Plan:
- SINGLE flit, dst=(0,0), MY=(0,0), grt_i tied high:
  - port_o=LOCAL, req_o high exactly 1 cycle at t+2, flit_o matches, 1 credit pulse, then IDLE.
- 4-flit packet (HEAD,BODY,BODY,TAIL), dst=(3,1), MY=(1,1), grt_i low for 3 cycles then high:
  - port_o=EAST, req_o held throughout, pops start on the first grant cycle, 4 credits, req_o drops the cycle after the TAIL pop.
- Packet dst=(1,0), MY=(1,2):
  - port_o=SOUTH.
- Flit gap inside a packet (BODY arrives 5 cycles late):
  - req_o stays 1 with valid_o=0 during the gap, no spurious credit.
- DEPTH=4, grt_i low, 5 writes:
  - 5th dropped, err_o=1.
- Same scenario but the 5th write coincides with a pop:
  - accepted, err_o stays 0.
- BODY flit arriving in IDLE:
  - discarded, 1 credit pulse, err_o=1, req_o never asserted.
- Reset asserted mid-packet with 2 flits buffered:
  - all outputs 0 immediately (async), FIFO empty after release, next HEAD routed normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout, port and flit-type encodings, XY route helper.
package noc_pkg;

  localparam int unsigned PORT_N = 5;
  localparam int unsigned PORT_W = $clog2(PORT_N);
  localparam int unsigned X_W    = 2;
  localparam int unsigned Y_W    = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    HEAD   = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    SINGLE = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e        ftype;
    logic [X_W-1:0]    dst_x;
    logic [Y_W-1:0]    dst_y;
    logic [DATA_W-1:0] payload;
  } flit_t;

  // Dimension-ordered routing: resolve X fully before Y.
  function automatic port_e xy_route(
    input logic [X_W-1:0] dst_x,
    input logic [Y_W-1:0] dst_y,
    input logic [X_W-1:0] my_x,
    input logic [Y_W-1:0] my_y
  );
    port_e p;
    if (dst_x > my_x)      p = EAST;
    else if (dst_x < my_x) p = WEST;
    else if (dst_y > my_y) p = NORTH;
    else if (dst_y < my_y) p = SOUTH;
    else                   p = LOCAL;
    return p;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module noc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: flit buffer, XY route of the head flit, and the crossbar
// request/stream handshake with one upstream credit per forwarded flit.
module noc_input_unit
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MY_X  = 0,
  parameter int unsigned MY_Y  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  flit_t             flit_i,
  output logic              credit_o,
  output logic              req_o,
  output logic [PORT_W-1:0] port_o,
  input  logic              grt_i,
  output logic              valid_o,
  output flit_t             flit_o,
  output logic              err_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [X_W-1:0] MY_XV = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_YV = Y_W'(MY_Y);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e                   state;
  port_e                    port_q;
  logic [$bits(flit_t)-1:0] head_raw;
  flit_t                    head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic                     is_first;
  logic                     is_last;
  logic                     discard;
  logic                     pop;
  logic                     drop;

  noc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(flit_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid_i),
    .din   (flit_i),
    .pop   (pop),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head     = flit_t'(head_raw);
  assign is_first = (head.ftype == HEAD) || (head.ftype == SINGLE);
  assign is_last  = (head.ftype == TAIL) || (head.ftype == SINGLE);

  // A stray BODY/TAIL at the head while idle is drained so the port cannot wedge.
  assign discard  = (state == IDLE) && !fifo_empty && !is_first;
  assign pop      = discard || ((state == ACTIVE) && grt_i && !fifo_empty);
  assign drop     = valid_i && fifo_full && !pop;

  assign credit_o = pop;
  assign valid_o  = (state == ACTIVE) && (fifo_count != '0);
  assign flit_o   = valid_o ? head : '0;
  assign port_o   = port_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      port_q <= LOCAL;
      err_o  <= 1'b0;
    end else begin
      if (drop || discard) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty && is_first) begin
            port_q <= xy_route(head.dst_x, head.dst_y, MY_XV, MY_YV);
            req_o  <= 1'b1;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop && is_last) begin
            req_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// Scoreboard bench for noc_input_unit: directed packets push expected
// (port, flit) pairs; a negedge monitor checks every flit taken by the crossbar.
module tb_noc_input_unit;
  import noc_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  flit_t             flit_i;
  logic              credit_o;
  logic              req_o;
  logic [PORT_W-1:0] port_o;
  logic              grt_i;
  logic              valid_o;
  flit_t             flit_o;
  logic              err_o;

  noc_input_unit #(
    .DEPTH (4),
    .MY_X  (1),
    .MY_Y  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .flit_i   (flit_i),
    .credit_o (credit_o),
    .req_o    (req_o),
    .port_o   (port_o),
    .grt_i    (grt_i),
    .valid_o  (valid_o),
    .flit_o   (flit_o),
    .err_o    (err_o)
  );

  typedef struct packed {
    logic [PORT_W-1:0] port;
    flit_t             flit;
  } exp_t;

  exp_t exp_q[$];
  int   passed;
  int   total;
  int   credit_cnt;
  int   c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic flit_t mk(input flit_type_e t, input logic [1:0] x, input logic [1:0] y,
                               input logic [31:0] p);
    flit_t f;
    f.ftype   = t;
    f.dst_x   = x;
    f.dst_y   = y;
    f.payload = p;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input flit_t f, input port_e p, input bit track);
    exp_t e;
    step();
    valid_i = 1'b1;
    flit_i  = f;
    if (track) begin
      e.port = p;
      e.flit = f;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_in();
    step();
    valid_i = 1'b0;
    flit_i  = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    grt_i   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Monitor: a flit is consumed whenever valid_o and grt_i coincide.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (credit_o) credit_cnt++;
      if (rst_n && valid_o && grt_i) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_flit: got %0h, expected none", flit_o);
        end else begin
          e = exp_q.pop_front();
          check("mon_flit", flit_o, e.flit);
          check("mon_port", port_o, e.port);
          check("mon_req", req_o, 1'b1);
        end
      end
    end
  end

  initial begin
    passed = 0; total = 0; credit_cnt = 0;
    valid_i = 1'b0; flit_i = '0; grt_i = 1'b0; rst_n = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req", req_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_credit", credit_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_port", port_o, 3'd0);
    check("rst_flit", flit_o, '0);
    step();
    rst_n = 1'b1;

    // SINGLE to self, grant tied high
    grt_i = 1'b1;
    c0 = credit_cnt;
    send(mk(SINGLE, 2'd1, 2'd1, 32'h1111_0001), LOCAL, 1'b1);
    idle_in();
    @(negedge clk); check("t1_req_t1", req_o, 1'b0);
    @(negedge clk); check("t1_req_t2", req_o, 1'b1); check("t1_valid_t2", valid_o, 1'b1);
    @(negedge clk); check("t1_req_drop", req_o, 1'b0);
    step(); check("t1_credits", credit_cnt - c0, 1);

    // 4-flit packet east, grant withheld then given
    grt_i = 1'b0;
    c0 = credit_cnt;
    send(mk(HEAD, 2'd3, 2'd1, 32'hA000_0000), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hA000_0001), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hA000_0002), EAST, 1'b1);
    send(mk(TAIL, 2'd3, 2'd1, 32'hA000_0003), EAST, 1'b1);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_req_stall", req_o, 1'b1);
      check("t2_credit_stall", credit_o, 1'b0);
    end
    step();
    grt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_credit_grant", credit_o, 1'b1);
      check("t2_req_held", req_o, 1'b1);
    end
    @(negedge clk); check("t2_req_drop", req_o, 1'b0);
    step(); check("t2_credits", credit_cnt - c0, 4);

    // Route directions
    c0 = credit_cnt;
    send(mk(SINGLE, 2'd1, 2'd0, 32'hB000_0001), SOUTH, 1'b1);
    send(mk(SINGLE, 2'd0, 2'd2, 32'hB000_0002), WEST, 1'b1);
    send(mk(SINGLE, 2'd1, 2'd3, 32'hB000_0003), NORTH, 1'b1);
    idle_in();
    repeat (8) step();
    check("t3_credits", credit_cnt - c0, 3);

    // Gap inside a packet
    c0 = credit_cnt;
    send(mk(HEAD, 2'd0, 2'd2, 32'hC000_0000), WEST, 1'b1);
    idle_in();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_gap_req", req_o, 1'b1);
      check("t4_gap_valid", valid_o, 1'b0);
      check("t4_gap_credit", credit_o, 1'b0);
    end
    step(); check("t4_gap_credits", credit_cnt - c0, 1);
    repeat (2) step();
    send(mk(BODY, 2'd0, 2'd2, 32'hC000_0001), WEST, 1'b1);
    send(mk(TAIL, 2'd0, 2'd2, 32'hC000_0002), WEST, 1'b1);
    idle_in();
    repeat (6) step();
    check("t4_credits", credit_cnt - c0, 3);
    check("t4_req_end", req_o, 1'b0);

    // Overflow: fifth write into a full FIFO with no pop
    grt_i = 1'b0;
    c0 = credit_cnt;
    send(mk(HEAD, 2'd3, 2'd1, 32'hD000_0000), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hD000_0001), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hD000_0002), EAST, 1'b1);
    send(mk(TAIL, 2'd3, 2'd1, 32'hD000_0003), EAST, 1'b1);
    send(mk(SINGLE, 2'd1, 2'd1, 32'hD000_0004), LOCAL, 1'b0);
    check("t5_err_before", err_o, 1'b0);
    idle_in();
    check("t5_err_overflow", err_o, 1'b1);
    grt_i = 1'b1;
    repeat (8) step();
    grt_i = 1'b0;
    check("t5_credits", credit_cnt - c0, 4);
    do_reset();
    check("t5_err_reset", err_o, 1'b0);

    // Full FIFO write coinciding with a pop
    c0 = credit_cnt;
    send(mk(HEAD, 2'd3, 2'd1, 32'hE000_0000), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hE000_0001), EAST, 1'b1);
    send(mk(BODY, 2'd3, 2'd1, 32'hE000_0002), EAST, 1'b1);
    send(mk(TAIL, 2'd3, 2'd1, 32'hE000_0003), EAST, 1'b1);
    send(mk(SINGLE, 2'd1, 2'd1, 32'hE000_0004), LOCAL, 1'b1);
    grt_i = 1'b1;
    idle_in();
    repeat (10) step();
    grt_i = 1'b0;
    check("t6_err", err_o, 1'b0);
    check("t6_credits", credit_cnt - c0, 5);

    // BODY arriving while idle
    c0 = credit_cnt;
    send(mk(BODY, 2'd1, 2'd1, 32'hF000_0001), LOCAL, 1'b0);
    idle_in();
    @(negedge clk); check("t7_credit", credit_o, 1'b1); check("t7_req0", req_o, 1'b0);
    @(negedge clk); check("t7_err", err_o, 1'b1); check("t7_req1", req_o, 1'b0);
    @(negedge clk); check("t7_req2", req_o, 1'b0);
    step(); check("t7_credits", credit_cnt - c0, 1);

    // Asynchronous reset mid-packet
    send(mk(HEAD, 2'd3, 2'd1, 32'h9000_0000), EAST, 1'b0);
    send(mk(BODY, 2'd3, 2'd1, 32'h9000_0001), EAST, 1'b0);
    idle_in();
    @(negedge clk);
    check("t8_req_pre", req_o, 1'b1);
    check("t8_valid_pre", valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_req_async", req_o, 1'b0);
    check("t8_valid_async", valid_o, 1'b0);
    check("t8_credit_async", credit_o, 1'b0);
    check("t8_err_async", err_o, 1'b0);
    check("t8_port_async", port_o, 3'd0);
    check("t8_flit_async", flit_o, '0);
    repeat (2) step();
    rst_n = 1'b1;
    grt_i = 1'b1;
    @(negedge clk);
    check("t8_valid_post", valid_o, 1'b0);
    check("t8_req_post", req_o, 1'b0);
    c0 = credit_cnt;
    send(mk(HEAD, 2'd1, 2'd3, 32'h9100_0000), NORTH, 1'b1);
    send(mk(TAIL, 2'd1, 2'd3, 32'h9100_0001), NORTH, 1'b1);
    idle_in();
    repeat (8) step();
    grt_i = 1'b0;
    check("t8_credits", credit_cnt - c0, 2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
